sensor_fault_monitor: RTL and testbench



---
 rtl/sensor_fault_monitor.sv | 141 ++++++++++++++
 tb/tb_sensor_fault_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_fault_monitor.sv
// Periodic 4-bit sensor fault sampler with debounce and latched alarm.
// Optional cause capture: define SENSOR_FAULT_MONITOR_CAUSE_EN.
module sensor_fault_monitor #(
    parameter int PERIOD   = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] sensors,
    input  logic       ack,
    output logic       sample_strobe,
    output logic       alarm,
    output logic [3:0] fault_count,
    output logic [2:0] cause
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EVAL,
        S_ALARM
    } state_t;

    localparam logic [7:0] PLAST = 8'(PERIOD - 1);
    localparam logic [3:0] DLAST = 4'(DEBOUNCE - 1);

    state_t     state_q, state_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic [3:0] samp_q, samp_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic       fault;
    logic       raise;
    logic       leave;

    assign fault = samp_q[0] | (samp_q[1] & (samp_q[2] | samp_q[3]));

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        samp_d  = samp_q;
        fcnt_d  = fcnt_q;
        raise   = 1'b0;
        leave   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pcnt_d = '0;
                hcnt_d = '0;
                samp_d = '0;
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                    hcnt_d  = '0;
                end else if (pcnt_q == PLAST) begin
                    samp_d  = sensors;
                    pcnt_d  = '0;
                    state_d = S_EVAL;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            S_EVAL: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    hcnt_d  = '0;
                end else if (!fault) begin
                    hcnt_d  = '0;
                    state_d = S_WAIT;
                end else if (hcnt_q == DLAST) begin
                    hcnt_d  = '0;
                    state_d = S_ALARM;
                    raise   = 1'b1;
                    if (fcnt_q != 4'hF) fcnt_d = fcnt_q + 4'd1;
                end else begin
                    hcnt_d  = hcnt_q + 4'd1;
                    state_d = S_WAIT;
                end
            end
            S_ALARM: begin
                // Disabling never drops a pending alarm; only ack leaves.
                if (ack) begin
                    leave   = 1'b1;
                    pcnt_d  = '0;
                    hcnt_d  = '0;
                    state_d = enable ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            samp_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            hcnt_q  <= hcnt_d;
            samp_q  <= samp_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign sample_strobe = (state_q == S_WAIT) && (pcnt_q == PLAST);
    assign alarm         = (state_q == S_ALARM);
    assign fault_count   = fcnt_q;

`ifdef SENSOR_FAULT_MONITOR_CAUSE_EN
    logic [2:0] cause_q, cause_d;

    always_comb begin
        cause_d = cause_q;
        if (raise) begin
            cause_d = {samp_q[1] & samp_q[3], samp_q[1] & samp_q[2], samp_q[0]};
        end else if (leave) begin
            cause_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cause_q <= '0;
        else     cause_q <= cause_d;
    end

    assign cause = cause_q;
`else
    logic unused_cause;
    assign unused_cause = raise | leave;
    assign cause        = 3'b000;
`endif

endmodule

// File: tb/tb_sensor_fault_monitor.sv
// Directed + randomized bench for sensor_fault_monitor against a
// tick/streak reference model.
module tb_sensor_fault_monitor;

    localparam int PERIOD   = 4;
    localparam int DEBOUNCE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] sensors;
    logic       ack;
    logic       sample_strobe;
    logic       alarm;
    logic [3:0] fault_count;
    logic [2:0] cause;

    sensor_fault_monitor #(
        .PERIOD  (PERIOD),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sensors      (sensors),
        .ack          (ack),
        .sample_strobe(sample_strobe),
        .alarm        (alarm),
        .fault_count  (fault_count),
        .cause        (cause)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0=off, 1=running, 2=alarm.
    // tick counts 0..PERIOD within one sample interval; PERIOD is the eval cycle.
    int         m_mode = 0;
    int         m_tick = 0;
    int         m_streak = 0;
    int         m_cnt = 0;
    int         m_evals = 0;
    logic [3:0] m_smp = '0;
    logic [2:0] m_cause = '0;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic e, input logic [3:0] s,
                         input logic a, input logic r);
        bit f;
        if (r) begin
            m_mode = 0; m_tick = 0; m_streak = 0;
            m_cnt = 0; m_smp = '0; m_cause = '0;
            return;
        end
        case (m_mode)
            0: begin
                m_tick = 0; m_streak = 0; m_smp = '0;
                if (e) m_mode = 1;
            end
            1: begin
                if (!e) begin
                    m_mode = 0; m_tick = 0; m_streak = 0;
                end else if (m_tick == PERIOD - 1) begin
                    m_smp = s;
                    m_tick = PERIOD;
                end else if (m_tick == PERIOD) begin
                    m_evals++;
                    m_tick = 0;
                    f = m_smp[0] || (m_smp[1] && m_smp[3]) || (m_smp[1] && m_smp[2]);
                    if (!f) m_streak = 0;
                    else begin
                        m_streak++;
                        if (m_streak == DEBOUNCE) begin
                            m_streak = 0;
                            m_mode = 2;
                            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                            m_cause = {m_smp[1] & m_smp[3], m_smp[1] & m_smp[2], m_smp[0]};
                        end
                    end
                end else begin
                    m_tick++;
                end
            end
            default: begin
                if (a) begin
                    m_mode = e ? 1 : 0;
                    m_tick = 0; m_streak = 0; m_cause = '0;
                end
            end
        endcase
    endtask

    task automatic step(input logic e, input logic [3:0] s,
                        input logic a, input logic r);
        logic [2:0] exp_cause;
        enable = e; sensors = s; ack = a; rst = r;
        @(posedge clk);
        model(e, s, a, r);
        #1;
`ifdef SENSOR_FAULT_MONITOR_CAUSE_EN
        exp_cause = m_cause;
`else
        exp_cause = 3'b000;
`endif
        check("strobe", 8'(sample_strobe), 8'(m_mode == 1 && m_tick == PERIOD - 1));
        check("alarm", 8'(alarm), 8'(m_mode == 2));
        check("fault_count", 8'(fault_count), 8'(m_cnt));
        check("cause", 8'(cause), 8'(exp_cause));
    endtask

    // Run with enable=1 until exactly one more evaluation has happened.
    task automatic do_sample(input logic [3:0] s);
        int e0;
        e0 = m_evals;
        for (int i = 0; i < 20 && m_evals == e0; i++) step(1'b1, s, 1'b0, 1'b0);
        check("sample_timeout", 8'(m_evals != e0), 8'd1);
    endtask

    initial begin
        enable = 0; sensors = '0; ack = 0; rst = 1;

        // Reset state
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check("rst_alarm", 8'(alarm), 8'd0);
        check("rst_count", 8'(fault_count), 8'd0);
        check("rst_cause", 8'(cause), 8'd0);
        check("rst_strobe", 8'(sample_strobe), 8'd0);

        // Reset mid-debounce
        do_sample(4'b0001);
        do_sample(4'b0001);
        step(1'b1, 4'b0001, 1'b0, 1'b1);
        check("middeb_alarm", 8'(alarm), 8'd0);
        check("middeb_count", 8'(fault_count), 8'd0);
        do_sample(4'b0001);
        do_sample(4'b0001);
        check("middeb_two", 8'(alarm), 8'd0);
        do_sample(4'b0001);
        check("middeb_three", 8'(alarm), 8'd1);
        step(1'b1, 4'h0, 1'b1, 1'b0);
        check("middeb_ack", 8'(alarm), 8'd0);

        // Basic alarm and cause
        step(1'b0, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) do_sample(4'b1010);
        check("basic_alarm", 8'(alarm), 8'd1);
        check("basic_count", 8'(fault_count), 8'd1);
`ifdef SENSOR_FAULT_MONITOR_CAUSE_EN
        check("basic_cause", 8'(cause), 8'b100);
`else
        check("basic_cause", 8'(cause), 8'b000);
`endif

        // Acknowledge held off while disabled
        for (int i = 0; i < 20; i++) begin
            step((i < 5) ? 1'b1 : 1'b0, 4'b1010, 1'b0, 1'b0);
            check("hold_alarm", 8'(alarm), 8'd1);
            check("hold_strobe", 8'(sample_strobe), 8'd0);
        end
        step(1'b0, 4'b1010, 1'b1, 1'b0);
        check("ack_alarm", 8'(alarm), 8'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1010, 1'b0, 1'b0);
            check("idle_strobe", 8'(sample_strobe), 8'd0);
        end

        // Glitch rejection
        step(1'b0, 4'h0, 1'b0, 1'b1);
        do_sample(4'b0011);
        do_sample(4'b0011);
        do_sample(4'b0100);
        do_sample(4'b0110);
        do_sample(4'b0110);
        check("glitch_none", 8'(alarm), 8'd0);
        do_sample(4'b0110);
        check("glitch_alarm", 8'(alarm), 8'd1);
        step(1'b1, 4'h0, 1'b1, 1'b0);

        // Saturation
        step(1'b0, 4'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < 3; j++) do_sample(4'b0001);
            check("sat_count", 8'(fault_count), 8'((k < 15) ? k : 15));
            step(1'b1, 4'h0, 1'b1, 1'b0);
        end

        // Ack outside ALARM
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 4'h0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 15) != 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
